// File: rtl/memory_unit.sv
// Dual-port shared buffer: one array owned by either the CPU port (A) or the
// accelerator port (B), with a registered "CPU filled the buffer" flag.
module memory_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a_i,
    output logic [DATA_W-1:0] data_a_o,
    input  logic              cs_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b_i,
    output logic [DATA_W-1:0] data_b_o,
    input  logic              cs_b,
    input  logic              we_b,
    input  logic              sel,
    output logic              flag_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] data_a_q;
    logic [DATA_W-1:0] data_a_d;
    logic [DATA_W-1:0] data_b_q;
    logic [DATA_W-1:0] data_b_d;
    logic              flag_q;
    logic              flag_d;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              rd_a_s;
    logic              rd_b_s;
    logic              fill_done_s;

    // Decode owner access: the single write path is muxed from whichever port owns the buffer.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        wr_data_s = {DATA_W{1'b0}};
        if (sel == 1'b0) begin
            wr_en_s   = cs_a & we_a;
            wr_addr_s = addr_a;
            wr_data_s = data_a_i;
        end else begin
            wr_en_s   = cs_b & we_b;
            wr_addr_s = addr_b;
            wr_data_s = data_b_i;
        end
        rd_a_s      = cs_a & ~we_a;
        rd_b_s      = cs_b & ~we_b;
        fill_done_s = (~sel) & cs_a & we_a & (addr_a == {ADDR_W{1'b1}});
    end

    // Next read data per port: non-owner reads return zero, idle or write cycles hold.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (rd_a_s) begin
            if (sel == 1'b0) begin
                data_a_d = mem_q[addr_a];
            end else begin
                data_a_d = {DATA_W{1'b0}};
            end
        end else begin
            data_a_d = data_a_q;
        end
        if (rd_b_s) begin
            if (sel == 1'b1) begin
                data_b_d = mem_q[addr_b];
            end else begin
                data_b_d = {DATA_W{1'b0}};
            end
        end else begin
            data_b_d = data_b_q;
        end
    end

    // Flag next state: handing the buffer to the accelerator clears it.
    always_comb begin
        flag_d = flag_q;
        if (sel == 1'b1) begin
            flag_d = 1'b0;
        end else if (fill_done_s) begin
            flag_d = 1'b1;
        end else begin
            flag_d = flag_q;
        end
    end

    // Array storage; contents survive reset, but writes are dropped while reset is held.
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered outputs with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a_q <= {DATA_W{1'b0}};
            data_b_q <= {DATA_W{1'b0}};
            flag_q   <= 1'b0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            flag_q   <= flag_d;
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;
    assign flag_o   = flag_q;

endmodule

// File: tb/tb_memory_unit.sv
// Scoreboard bench for memory_unit: reads push expected data, a negedge monitor pops and compares.
module tb_memory_unit;

    logic       clk;
    logic       rst;
    logic [7:0] addr_a;
    logic [7:0] data_a_i;
    logic [7:0] data_a_o;
    logic       cs_a;
    logic       we_a;
    logic [7:0] addr_b;
    logic [7:0] data_b_i;
    logic [7:0] data_b_o;
    logic       cs_b;
    logic       we_b;
    logic       sel;
    logic       flag_o;

    int checks;
    int failures;

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic       rd_pend_a;
    logic       rd_pend_b;

    memory_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr_a   (addr_a),
        .data_a_i (data_a_i),
        .data_a_o (data_a_o),
        .cs_a     (cs_a),
        .we_a     (we_a),
        .addr_b   (addr_b),
        .data_b_i (data_b_i),
        .data_b_o (data_b_o),
        .cs_b     (cs_b),
        .we_b     (we_b),
        .sel      (sel),
        .flag_o   (flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks which ports issued a read on the last edge, so the monitor knows when output is due.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_a <= 1'b0;
            rd_pend_b <= 1'b0;
        end else begin
            rd_pend_a <= cs_a & ~we_a;
            rd_pend_b <= cs_b & ~we_b;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected read data one cycle after each read was issued.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rd_pend_a) begin
            if (qa.size() == 0) begin
                check("read_a_unexpected", data_a_o, 8'hxx);
            end else begin
                e = qa.pop_front();
                check("read_a", data_a_o, e);
            end
        end
        if (rd_pend_b) begin
            if (qb.size() == 0) begin
                check("read_b_unexpected", data_b_o, 8'hxx);
            end else begin
                e = qb.pop_front();
                check("read_b", data_b_o, e);
            end
        end
    end

    task automatic op(input logic s,
                      input logic ca, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                      input logic cb, input logic wb, input logic [7:0] ab, input logic [7:0] db);
        sel      = s;
        cs_a     = ca;
        we_a     = wa;
        addr_a   = aa;
        data_a_i = da;
        cs_b     = cb;
        we_b     = wb;
        addr_b   = ab;
        data_b_i = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic s);
        op(s, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        sel      = 1'b0;
        cs_a     = 1'b0;
        we_a     = 1'b0;
        addr_a   = 8'h00;
        data_a_i = 8'h00;
        cs_b     = 1'b0;
        we_b     = 1'b0;
        addr_b   = 8'h00;
        data_b_i = 8'h00;

        #1 rst = 1'b0;
        #3;
        check("reset_data_a", data_a_o, 8'h00);
        check("reset_data_b", data_b_o, 8'h00);
        check("reset_flag", {7'd0, flag_o}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // CPU fills the whole buffer; flag only rises on the last address.
        for (int i = 0; i < 256; i++) begin
            op(1'b0, 1'b1, 1'b1, 8'(i), 8'(i), 1'b0, 1'b0, 8'h00, 8'h00);
            check($sformatf("fill_flag_%0d", i), {7'd0, flag_o}, (i == 255) ? 8'h01 : 8'h00);
        end
        check("write_no_through_a", data_a_o, 8'h00);

        // Accelerator takes ownership and reads back-to-back.
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        qb.push_back(8'h00);
        check("flag_clear_on_sel1", {7'd0, flag_o}, 8'h00);
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00);
        qb.push_back(8'h01);
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
        qb.push_back(8'h02);
        idle(1'b1);
        idle(1'b1);
        check("hold_b_when_idle", data_b_o, 8'h02);

        // Owner B write, then CPU reads it after taking the buffer back.
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
        check("write_no_through_b", data_b_o, 8'h02);
        op(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'hA5);

        // Non-owner B write is ignored, non-owner B read returns zero.
        op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
        op(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00);
        qa.push_back(8'h20);
        qb.push_back(8'h00);
        // Non-owner A read returns zero while B owns the buffer.
        op(1'b1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'h00);

        // Set the flag and load 0x55 into data_a_o, then reset mid-cycle.
        op(1'b0, 1'b1, 1'b1, 8'hFF, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
        op(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'h55);
        idle(1'b0);
        check("flag_before_reset", {7'd0, flag_o}, 8'h01);
        check("data_a_before_reset", data_a_o, 8'h55);
        sel      = 1'b0;
        cs_a     = 1'b1;
        we_a     = 1'b1;
        addr_a   = 8'h30;
        data_a_i = 8'h99;
        #2 rst = 1'b0;
        #1;
        check("async_reset_flag", {7'd0, flag_o}, 8'h00);
        check("async_reset_data_a", data_a_o, 8'h00);
        check("async_reset_data_b", data_b_o, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        cs_a = 1'b0;
        we_a = 1'b0;
        op(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'hA5);
        op(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'h30);
        check("flag_after_reset", {7'd0, flag_o}, 8'h00);

        // Last-address write sets the flag; read-back follows one cycle later.
        op(1'b0, 1'b1, 1'b1, 8'hFF, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
        check("flag_last_addr", {7'd0, flag_o}, 8'h01);
        op(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        qa.push_back(8'h77);
        idle(1'b0);
        idle(1'b0);
        check("flag_holds", {7'd0, flag_o}, 8'h01);
        check("hold_a_when_idle", data_a_o, 8'h77);

        check("queue_a_drained", 8'(qa.size()), 8'h00);
        check("queue_b_drained", 8'(qb.size()), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set address width; depth = 2**ADDR_W bytes.
REQ-002 Parameter DATA_W, default 8, SHALL set data width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 addr_a  input  ADDR_W  port A (CPU) address.
REQ-006 data_a_i  input  DATA_W  port A write data.
REQ-007 data_a_o  output  DATA_W  port A registered read data.
REQ-008 cs_a  input  1  port A chip select.
REQ-009 we_a  input  1  port A write enable; 1 = write, 0 = read; qualified by cs_a.
REQ-010 addr_b  input  ADDR_W  port B (accelerator) address.
REQ-011 data_b_i  input  DATA_W  port B write data.
REQ-012 data_b_o  output  DATA_W  port B registered read data.
REQ-013 cs_b  input  1  port B chip select.
REQ-014 we_b  input  1  port B write enable; qualified by cs_b.
REQ-015 sel  input  1  buffer owner; 0 = port A (CPU), 1 = port B (accelerator).
REQ-016 flag_o  output  1  registered "buffer filled by CPU" flag.

Function
REQ-017 Storage SHALL be one shared array of 2**ADDR_W words of DATA_W bits.
REQ-018 Only the owner port SHALL access the array: port A when sel=0, port B when sel=1.
REQ-019 Owner write: cs & we at rising edge SHALL store data_i at addr that edge.
REQ-020 Owner read: cs & !we at edge N SHALL present mem[addr] on the port's data_o from edge N until the next read of that port.
REQ-021 Read latency SHALL be exactly 1 cycle; consecutive reads every cycle SHALL be supported.
REQ-022 Owner write SHALL NOT change that port's data_o (no write-through).
REQ-023 With cs=0, the port's data_o SHALL hold its last value.
REQ-024 Non-owner access: writes SHALL be ignored (array unchanged); reads SHALL load 0 into that port's data_o.
REQ-025 sel SHALL be sampled on the same edge as cs/we; a change takes effect for accesses at that edge.
REQ-026 flag_o SHALL set to 1 on an edge where sel=0, cs_a=1, we_a=1, addr_a = all ones (last address).
REQ-027 flag_o SHALL clear to 0 on any edge where sel=1.
REQ-028 Otherwise flag_o SHALL hold; set and clear never coincide because set requires sel=0.
REQ-029 Addresses SHALL be treated as unsigned; no wrap or bounds logic inside the block (callers wrap at all ones).
REQ-030 Array contents SHALL persist across sel changes.

Reset
REQ-031 rst=0 SHALL asynchronously force data_a_o=0, data_b_o=0, flag_o=0, independent of clk.
REQ-032 Array contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-033 While rst=0, all accesses SHALL be ignored; an access in flight when reset asserts SHALL be dropped.
REQ-034 Normal operation SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-035 sel=0; port A writes 0x00..0xFF to addresses 0x00..0xFF -> flag_o=0 through the write to 0xFE; flag_o=1 after the edge writing 0xFF.
REQ-036 Then sel=1; port B reads 0x00, 0x01, 0x02 on consecutive cycles -> data_b_o = 0x00, 0x01, 0x02, each one cycle after its address; flag_o=0 after the first sel=1 edge.
REQ-037 sel=1; port B writes 0xA5 @0x10; then sel=0; port A reads 0x10 -> data_a_o=0xA5 one cycle later.
REQ-038 sel=0; port B writes 0x3C @0x20 -> ignored (A reads back the prior value); port B read -> data_b_o=0x00.
REQ-039 flag_o=1, data_a_o=0x55; assert rst=0 mid-cycle -> flag_o=0, data_a_o=0, data_b_o=0 immediately; earlier written array data still readable after release.
REQ-040 sel=0; port A writes 0x77 @0xFF and reads 0xFF next cycle -> flag_o=1, data_a_o=0x77.
